// File: rtl/poly_voice_sampler_if.sv
// Bus bundle for poly_voice_sampler: keycode/tick input, SRAM read port, mixed audio out.
// master = the sampler, slave = its surroundings (keycode source, SRAM, codec).
interface poly_voice_sampler_if #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 8,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16
);
    logic                        sample_tick;
    logic [NUM_VOICES*KEY_W-1:0] keycodes;
    logic [DATA_W-1:0]           sram_data;
    logic [ADDR_W-1:0]           sram_addr;
    logic                        sram_oe;
    logic [DATA_W-1:0]           audio_data;
    logic                        audio_valid;
    logic                        busy;
    logic                        overrun;
    logic [NUM_VOICES-1:0]       voice_active;

    modport master (
        input  sample_tick, keycodes, sram_data,
        output sram_addr, sram_oe, audio_data, audio_valid, busy, overrun, voice_active
    );
    modport slave (
        output sample_tick, keycodes, sram_data,
        input  sram_addr, sram_oe, audio_data, audio_valid, busy, overrun, voice_active
    );
endinterface

// File: rtl/poly_voice_sampler.sv
// NUM_VOICES-voice sample player sharing one SRAM read port, mixed with signed saturation.
// Define NOTE_LOOP_EN to make voices wrap to offset 0 at end of sample instead of ending.
module poly_voice_lane #(
    parameter int KEY_W      = 8,
    parameter int OFF_W      = 12,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_LEN = 4096
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    latch,
    input  logic [KEY_W-1:0]        key,
    input  logic                    capture,
    input  logic [DATA_W-1:0]       sram_data,
    input  logic                    advance,
    output logic [KEY_W+OFF_W-1:0]  addr,
    output logic                    active,
    output logic [DATA_W-1:0]       sample
);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(SAMPLE_LEN - 1);

    logic [KEY_W-1:0] key_q;
    logic [OFF_W-1:0] off;

    assign addr = {key_q, off};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_q  <= '0;
            off    <= '0;
            active <= 1'b0;
            sample <= '0;
        end else begin
            // Only a keycode change (re)starts a voice; holding the key after it ends does not.
            if (latch && key != key_q) begin
                off    <= '0;
                active <= (key != '0);
            end
            if (latch)
                key_q <= key;
            if (capture)
                sample <= active ? sram_data : '0;
            if (advance && active) begin
                if (off == LAST) begin
`ifdef NOTE_LOOP_EN
                    off <= '0;
`else
                    active <= 1'b0;
`endif
                end else begin
                    off <= off + OFF_W'(1);
                end
            end
        end
    end
endmodule

module poly_voice_sampler #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 8,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_LEN = 4096,
    parameter int SRAM_WAIT  = 1
) (
    input  logic Clk,
    input  logic Reset,
    poly_voice_sampler_if.master bus
);
    localparam int OFF_W  = ADDR_W - KEY_W;
    localparam int VI_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int WAIT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam int SUM_W  = DATA_W + $clog2(NUM_VOICES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_SUM     = 3'd5;

    localparam logic signed [SUM_W-1:0] MAXS = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MINS = ~MAXS;

    logic [2:0]        state;
    logic [VI_W-1:0]   vidx;
    logic [WAIT_W-1:0] wcnt;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_oe;
    logic [DATA_W-1:0] audio_data;
    logic              audio_valid;
    logic              overrun;

    logic [NUM_VOICES-1:0][ADDR_W-1:0] lane_addr;
    logic [NUM_VOICES-1:0][DATA_W-1:0] lane_sample;
    logic [NUM_VOICES-1:0]             lane_active;

    logic latch_stb, cap_stb, adv_stb;
    logic [VI_W-1:0] vnext;

    assign latch_stb = (state == S_IDLE) && bus.sample_tick;
    assign cap_stb   = ((state == S_ISSUE) && (SRAM_WAIT == 0)) ||
                       ((state == S_WAIT) && (wcnt == WAIT_W'(SRAM_WAIT - 1)));
    assign adv_stb   = (state == S_SUM);
    assign vnext     = vidx + VI_W'(1);

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lane
        poly_voice_lane #(
            .KEY_W(KEY_W), .OFF_W(OFF_W), .DATA_W(DATA_W), .SAMPLE_LEN(SAMPLE_LEN)
        ) u_lane (
            .Clk      (Clk),
            .Reset    (Reset),
            .latch    (latch_stb),
            .key      (bus.keycodes[v*KEY_W +: KEY_W]),
            .capture  (cap_stb && (vidx == VI_W'(v))),
            .sram_data(bus.sram_data),
            .advance  (adv_stb),
            .addr     (lane_addr[v]),
            .active   (lane_active[v]),
            .sample   (lane_sample[v])
        );
    end

    logic signed [SUM_W-1:0] sum;
    logic [DATA_W-1:0]       sat;

    always_comb begin
        sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            sum = sum + SUM_W'($signed(lane_sample[v]));
        sat = sum[DATA_W-1:0];
        if (sum > MAXS)
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        else if (sum < MINS)
            sat = {1'b1, {(DATA_W-1){1'b0}}};
    end

    // Each action is registered on the edge that enters its state, so the
    // outputs of a state are visible during that state's cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            vidx        <= '0;
            wcnt        <= '0;
            sram_addr   <= '0;
            sram_oe     <= 1'b0;
            audio_data  <= '0;
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= bus.sample_tick && (state != S_IDLE);
            case (state)
                S_IDLE: if (bus.sample_tick) state <= S_LATCH;
                S_LATCH: begin
                    vidx      <= '0;
                    sram_addr <= lane_addr[0];
                    sram_oe   <= lane_active[0];
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    wcnt <= '0;
                    if (cap_stb) begin
                        sram_oe <= 1'b0;
                        state   <= S_CAPTURE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cap_stb) begin
                        sram_oe <= 1'b0;
                        state   <= S_CAPTURE;
                    end else begin
                        wcnt <= wcnt + WAIT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (vidx == VI_W'(NUM_VOICES - 1)) begin
                        audio_data  <= sat;
                        audio_valid <= 1'b1;
                        state       <= S_SUM;
                    end else begin
                        vidx      <= vnext;
                        sram_addr <= lane_addr[vnext];
                        sram_oe   <= lane_active[vnext];
                        state     <= S_ISSUE;
                    end
                end
                S_SUM: begin
                    audio_valid <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sram_addr    = sram_addr;
    assign bus.sram_oe      = sram_oe;
    assign bus.audio_data   = audio_data;
    assign bus.audio_valid  = audio_valid;
    assign bus.busy         = (state != S_IDLE);
    assign bus.overrun      = overrun;
    assign bus.voice_active = lane_active;
endmodule

// File: tb/tb_poly_voice_sampler.sv
// Directed bench for poly_voice_sampler (default parameters, NOTE_LOOP_EN-aware).
module tb_poly_voice_sampler;
    localparam int NV = 4, KW = 8, AW = 20, DW = 16;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    poly_voice_sampler_if #(.NUM_VOICES(NV), .KEY_W(KW), .ADDR_W(AW), .DATA_W(DW)) bus();

    poly_voice_sampler #(
        .NUM_VOICES(NV), .KEY_W(KW), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_LEN(4096), .SRAM_WAIT(1)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    // SRAM model: mode 0 returns addr[15:0], mode 1 returns a per-keycode constant
    logic        mode;
    logic [15:0] tab [256];
    assign bus.sram_data = mode ? tab[bus.sram_addr[19:12]] : bus.sram_addr[15:0];

    int n_cmp = 0, n_bad = 0;
    int valid_cnt = 0, ovr_cnt = 0;
    always @(negedge Clk) begin
        if (bus.audio_valid) valid_cnt++;
        if (bus.overrun) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          fr_n;
    logic [15:0] fr_data;
    logic [19:0] slot_addr [NV];
    logic        slot_oe   [NV];

    // One frame: tick in cycle 0, snapshot each voice's ISSUE cycle and the first audio_valid.
    task automatic frame();
        fr_n = 0;
        fr_data = '0;
        @(negedge Clk);
        bus.sample_tick = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge Clk);
            bus.sample_tick = 1'b0;
            for (int v = 0; v < NV; v++)
                if (n == 2 + 3*v) begin
                    slot_addr[v] = bus.sram_addr;
                    slot_oe[v]   = bus.sram_oe;
                end
            if (bus.audio_valid && fr_n == 0) begin
                fr_n = n;
                fr_data = bus.audio_data;
            end
        end
    endtask

    int vb, ob;

    initial begin
        mode = 1'b0;
        bus.sample_tick = 1'b0;
        bus.keycodes = '0;
        for (int i = 0; i < 256; i++) tab[i] = 16'h0000;
        tab[8'h21] = 16'h7000;
        tab[8'h22] = 16'h9000;
        tab[8'h23] = 16'h0100;
        tab[8'h24] = 16'hFF00;
        tab[8'h25] = 16'h1234;
        tab[8'h26] = 16'hF000;

        repeat (3) @(negedge Clk);
        chk("rst_addr",   bus.sram_addr, 0);
        chk("rst_oe",     bus.sram_oe, 0);
        chk("rst_audio",  bus.audio_data, 0);
        chk("rst_valid",  bus.audio_valid, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_ovr",    bus.overrun, 0);
        chk("rst_active", bus.voice_active, 0);
        Reset = 1'b0;

        // reset in the middle of a frame
        bus.keycodes = 32'h0000_0005;
        @(negedge Clk); bus.sample_tick = 1'b1;
        @(negedge Clk); bus.sample_tick = 1'b0;
        repeat (4) @(negedge Clk);
        chk("mid_busy", bus.busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midrst_busy",   bus.busy, 0);
        chk("midrst_oe",     bus.sram_oe, 0);
        chk("midrst_addr",   bus.sram_addr, 0);
        chk("midrst_active", bus.voice_active, 0);
        chk("midrst_valid",  bus.audio_valid, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        chk("midrst_no_valid", valid_cnt, 0);

        // single voice
        frame();
        chk("sv_addr0",  slot_addr[0], 20'h05000);
        chk("sv_oe0",    slot_oe[0], 1);
        chk("sv_oe1",    slot_oe[1], 0);
        chk("sv_lat",    fr_n, 14);
        chk("sv_data",   fr_data, 16'h5000);
        chk("sv_active", bus.voice_active, 4'b0001);
        frame();
        chk("sv2_addr0", slot_addr[0], 20'h05001);
        chk("sv2_data",  fr_data, 16'h5001);

        // second voice joins, then retriggers to a different key
        bus.keycodes = 32'h0000_0505;
        repeat (10) frame();
        chk("two_addr0",  slot_addr[0], 20'h0500B);
        chk("two_addr1",  slot_addr[1], 20'h05009);
        chk("two_active", bus.voice_active, 4'b0011);
        chk("two_data",   fr_data, 16'h7FFF);
        bus.keycodes = 32'h0000_0605;
        frame();
        chk("retrig_addr1", slot_addr[1], 20'h06000);
        chk("retrig_addr0", slot_addr[0], 20'h0500C);
        chk("retrig_oe1",   slot_oe[1], 1);

        // saturation and mixing
        mode = 1'b1;
        bus.keycodes = 32'h2121_2121;
        frame();
        chk("sat_pos",        fr_data, 16'h7FFF);
        chk("sat_pos_active", bus.voice_active, 4'b1111);
        bus.keycodes = 32'h2222_2222;
        frame();
        chk("sat_neg", fr_data, 16'h8000);
        bus.keycodes = 32'h0000_2423;
        frame();
        chk("cancel_data",   fr_data, 16'h0000);
        chk("cancel_active", bus.voice_active, 4'b0011);
        chk("cancel_oe2",    slot_oe[2], 0);
        bus.keycodes = 32'h0000_2625;
        frame();
        chk("mix_data", fr_data, 16'h0234);

        // overrun: second tick five cycles into the frame
        mode = 1'b0;
        bus.keycodes = 32'h0000_0007;
        vb = valid_cnt;
        ob = ovr_cnt;
        fr_n = 0;
        fr_data = '0;
        @(negedge Clk); bus.sample_tick = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge Clk);
            bus.sample_tick = (n == 5);
            if (bus.audio_valid && fr_n == 0) begin
                fr_n = n;
                fr_data = bus.audio_data;
            end
        end
        chk("ovr_pulses", ovr_cnt - ob, 1);
        chk("ovr_frames", valid_cnt - vb, 1);
        chk("ovr_lat",    fr_n, 14);
        chk("ovr_data",   fr_data, 16'h7000);
        frame();
        chk("ovr_next_data", fr_data, 16'h7001);

        // end of sample
        bus.keycodes = 32'h0000_0008;
        repeat (4095) frame();
        chk("eos_active_before", bus.voice_active, 4'b0001);
        frame();
        chk("eos_last_addr", slot_addr[0], 20'h08FFF);
        chk("eos_last_data", fr_data, 16'h8FFF);
`ifdef NOTE_LOOP_EN
        chk("eos_active_after", bus.voice_active, 4'b0001);
        frame();
        chk("loop_addr", slot_addr[0], 20'h08000);
        chk("loop_oe",   slot_oe[0], 1);
        chk("loop_data", fr_data, 16'h8000);
        frame();
        chk("loop_data2", fr_data, 16'h8001);
`else
        chk("eos_active_after", bus.voice_active, 4'b0000);
        frame();
        chk("ended_oe",   slot_oe[0], 0);
        chk("ended_data", fr_data, 16'h0000);
        chk("ended_lat",  fr_n, 14);
        frame();
        chk("ended_oe2",   slot_oe[0], 0);
        chk("ended_data2", fr_data, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/poly_voice_sampler.md
Name: poly_voice_sampler

Overview:
Parametrised successor of the four-voice note producer. Plays NUM_VOICES sample-playback voices from one shared SRAM, one read slot per voice per sample tick. Each voice has its own address sequencer. Voice samples are summed as signed values with saturation into one audio word per tick. Sits between the keycode source (USB/keyboard front end) and the audio codec interface; owns the SRAM read port during playback.

Parameters:
NUM_VOICES, 4, number of simultaneous voices (1..16)
KEY_W, 8, keycode width per voice; keycode 0 = voice silent
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM word / audio sample width (signed two's complement)
SAMPLE_LEN, 4096, words per note sample; must be <= 2**(ADDR_W-KEY_W)
SRAM_WAIT, 1, idle cycles between address issue and data capture (>=0)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
sample_tick  in  1  single-Clk-cycle strobe, one per audio sample period
keycodes  in  NUM_VOICES*KEY_W  voice v keycode = keycodes[v*KEY_W +: KEY_W]
sram_data  in  DATA_W  SRAM read data
sram_addr  out  ADDR_W  registered SRAM address
sram_oe  out  1  registered SRAM output enable, active-high
audio_data  out  DATA_W  mixed, saturated sample
audio_valid  out  1  one-cycle pulse when audio_data updates
busy  out  1  frame in progress
overrun  out  1  one-cycle pulse when sample_tick arrives while busy
voice_active  out  NUM_VOICES  bit v = voice v is playing

Behaviour:
- Reset (async): all outputs 0; all offsets 0; latched keycodes 0; FSM to IDLE. Reset asserted mid-frame aborts the frame with no audio_valid.
- Voice address = {keycode_v, offset_v} with offset width OFF_W = ADDR_W-KEY_W.
- FSM: IDLE -> (sample_tick) LATCH -> per voice v = 0..NUM_VOICES-1: ISSUE (1 cycle) -> WAIT (SRAM_WAIT cycles) -> CAPTURE (1 cycle) -> SUM (1 cycle) -> IDLE.
- LATCH: compare each keycode to its latched copy. On change, offset_v := 0 and voice_active[v] := (new keycode != 0). Then latch all keycodes.
- ISSUE: sram_addr := voice address. sram_oe := 1 only if voice_active[v], otherwise 0. Slot timing is fixed regardless of activity.
- CAPTURE: sample_v := sram_data if voice active, else 0. sram_oe := 0.
- SUM: signed sum of all sample_v at width DATA_W+clog2(NUM_VOICES).
  - Saturate to DATA_W: overflow gives 2**(DATA_W-1)-1, underflow gives -2**(DATA_W-1).
  - The result is registered into audio_data with audio_valid = 1 on the next cycle.
  - Each active voice then advances: offset_v+1. At offset_v == SAMPLE_LEN-1 the voice ends: voice_active[v] := 0, offset held.
- An ended voice restarts only when its keycode changes to a nonzero value.
- Latency: audio_valid rises L = NUM_VOICES*(SRAM_WAIT+2)+2 cycles after the sample_tick cycle. Default L = 14.
- busy = 1 from LATCH through SUM.
- sample_tick while busy: ignored, overrun pulses 1 cycle, current frame unaffected. sample_tick in the same cycle busy falls is accepted.
- Keycode changes mid-frame take effect only at the next LATCH.

Optional Feature:
NOTE_LOOP_EN. When defined, a voice at offset SAMPLE_LEN-1 wraps to offset 0 and stays active; the note sustains while its keycode is held. When undefined, the voice ends as described in Behaviour.

Test Plan:
- Reset: assert Reset mid-frame (default params) -> next cycle all outputs 0, busy 0; no audio_valid until the next tick.
- Single voice: keycodes = 0x00000005, SRAM model returns data = addr[15:0]. Tick 1 -> sram_addr 0x05000 with oe 1, audio_data 0x5000, audio_valid at cycle 14. Tick 2 -> 0x5001.
- Saturation: all four voices read 0x7000 -> audio_data 0x7FFF. All four read 0x9000 -> 0x8000. Reads 0x0100, 0xFF00, 0, 0 -> 0x0000.
- End of sample: one voice held for 4096 ticks -> voice_active drops after tick 4096, and later frames have oe 0 in that slot with audio 0. With NOTE_LOOP_EN: tick 4097 addresses 0x05000 again.
- Retrigger: change voice 1 keycode 0x05 -> 0x06 after 10 ticks -> next frame addresses 0x06000.
- Overrun: second sample_tick 5 cycles after the first -> overrun pulse; first frame still completes at cycle 14 with correct data; one frame only.
